alu_uart_interface: RTL
=======================

Name: alu_uart_interface

Overview:
- Sequencer between a UART receiver/transmitter pair and the combinational ALU.
- Collects three received bytes in order: operand A, operand B, opcode. Drives them onto the ALU inputs and captures the ALU result and flags.
- Returns two bytes through the UART transmitter: the result, then a flags byte.
- Sits directly upstream of the ALU, feeding its data and opcode inputs, and directly downstream of its outputs.

Parameters:
- NB_DATA, 8, width of operands, result, UART data bytes.
- NB_OP, 6, opcode width. Constraint: NB_OP <= NB_DATA.

Ports:
- i_clk  input  1  system clock, rising edge.
- i_reset  input  1  asynchronous, active-high reset.
- i_rx_data  input  NB_DATA  byte from UART receiver; valid when i_rx_done=1.
- i_rx_done  input  1  one-cycle pulse: new byte on i_rx_data.
- i_tx_done  input  1  one-cycle pulse: transmitter finished current byte.
- o_tx_start  output  1  one-cycle pulse: start transmitting o_tx_data.
- o_tx_data  output  NB_DATA  byte to transmit; stable from o_tx_start until i_tx_done.
- o_data_a  output  NB_DATA  operand A to ALU (signed).
- o_data_b  output  NB_DATA  operand B to ALU (signed).
- o_operation_code  output  NB_OP  opcode to ALU.
- i_alu_result  input  NB_DATA  ALU result.
- i_alu_overflow  input  1  ALU overflow flag.
- i_alu_zero  input  1  ALU zero flag.
- o_busy  output  1  high from EXEC through WAIT_FLAGS.

Behaviour:
- Reset (async, any state): state=WAIT_A; o_data_a, o_data_b, o_operation_code, o_tx_data, captured result/flags all 0; o_tx_start=0; o_busy=0.
- All outputs are driven from registers or decoded from the state register. No combinational path from any input to any output.
- WAIT_A: on i_rx_done, o_data_a<=i_rx_data; next state WAIT_B.
- WAIT_B: on i_rx_done, o_data_b<=i_rx_data; next state WAIT_OP.
- WAIT_OP: on i_rx_done, o_operation_code<=i_rx_data[NB_OP-1:0] (upper bits discarded); next state EXEC.
- EXEC (1 cycle): ALU inputs are already stable. Capture r_result<=i_alu_result and r_flags<={(NB_DATA-2) zeros, i_alu_overflow, i_alu_zero}. Next state SEND_RES.
- SEND_RES (1 cycle): o_tx_start=1, o_tx_data=r_result. Next state WAIT_RES.
- WAIT_RES: hold o_tx_data. On i_tx_done, next state SEND_FLAGS.
- SEND_FLAGS (1 cycle): o_tx_start=1, o_tx_data=r_flags. Next state WAIT_FLAGS.
- WAIT_FLAGS: on i_tx_done, next state WAIT_A.
- Latency: o_tx_start rises 2 cycles after the clock edge that samples the opcode's i_rx_done.
- Opcodes are not validated. An unsupported opcode yields the ALU's result (0), which is returned normally.
- i_rx_done while o_busy=1: byte dropped; no state or register change.
- i_tx_done outside WAIT_RES/WAIT_FLAGS: ignored, including a pulse coincident with SEND_RES/SEND_FLAGS.
- o_data_a, o_data_b, o_operation_code hold their values until overwritten by the next transaction, so the ALU output stays observable.
- o_tx_start never asserts for more than one consecutive cycle.
- No timeout: the FSM waits indefinitely in any WAIT state. Reset is the only abort.
- Reset mid-transaction: partial operands are discarded, and any in-flight tx handshake is abandoned (o_tx_start=0).

Test Plan:
- Rx 0x05, 0x03, 0x20 (ADD) -> o_data_a=0x05, o_data_b=0x03, o_operation_code=0x20. o_tx_start exactly 2 cycles after the opcode pulse with o_tx_data=0x08. After i_tx_done, second o_tx_start with 0x00.
- Rx 0x80, 0x01, 0x22 (SUB) -> tx 0x7F then flags 0x02 (overflow=1, zero=0).
- Rx 0x0F, 0xF0, 0x24 (AND) -> tx 0x00 then flags 0x01. Rx 0xFF, 0xFF, 0x3F (unsupported, low 6 bits of 0xFF) -> tx 0x00, 0x01.
- During WAIT_RES, inject i_rx_done with 0xAA; delay i_tx_done 50 cycles -> o_data_a unchanged, o_tx_data held 50 cycles, single-cycle o_tx_start. After the flags byte, the next rx byte loads A.
- Assert i_reset asynchronously after A and B are received -> all outputs 0 immediately, state WAIT_A. Next three bytes 0x02, 0x02, 0x20 -> tx 0x04, 0x00.
- Pulse i_tx_done in WAIT_A and in SEND_RES cycle -> no state change; the FSM still waits for the next i_tx_done in WAIT_RES.

Source files
------------

// File: rtl/alu_uart_interface_if.sv
// Signal bundle between the ALU/UART sequencer and its neighbours:
// the UART rx/tx handshake and the ALU operand/result lines.
interface alu_uart_interface_if #(
    parameter int NB_DATA = 8,
    parameter int NB_OP   = 6
);
    logic        [NB_DATA-1:0] i_rx_data;
    logic                      i_rx_done;
    logic                      i_tx_done;
    logic                      o_tx_start;
    logic        [NB_DATA-1:0] o_tx_data;
    logic signed [NB_DATA-1:0] o_data_a;
    logic signed [NB_DATA-1:0] o_data_b;
    logic        [NB_OP-1:0]   o_operation_code;
    logic        [NB_DATA-1:0] i_alu_result;
    logic                      i_alu_overflow;
    logic                      i_alu_zero;
    logic                      o_busy;

    // Sequencer side
    modport master (
        input  i_rx_data, i_rx_done, i_tx_done,
        input  i_alu_result, i_alu_overflow, i_alu_zero,
        output o_tx_start, o_tx_data,
        output o_data_a, o_data_b, o_operation_code, o_busy
    );

    // UART + ALU side
    modport slave (
        output i_rx_data, i_rx_done, i_tx_done,
        output i_alu_result, i_alu_overflow, i_alu_zero,
        input  o_tx_start, o_tx_data,
        input  o_data_a, o_data_b, o_operation_code, o_busy
    );
endinterface

// File: rtl/alu_uart_interface.sv
// Sequencer: receives A, B, opcode over UART, drives the ALU, and sends back
// the result byte followed by a flags byte {0.., overflow, zero}.
module alu_uart_interface #(
    parameter int NB_DATA = 8,
    parameter int NB_OP   = 6
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    alu_uart_interface_if.master   bus
);
    typedef enum logic [2:0] {
        WAIT_A,
        WAIT_B,
        WAIT_OP,
        EXEC,
        SEND_RES,
        WAIT_RES,
        SEND_FLAGS,
        WAIT_FLAGS
    } state_t;

    state_t                    state;
    logic signed [NB_DATA-1:0] data_a;
    logic signed [NB_DATA-1:0] data_b;
    logic        [NB_OP-1:0]   op_code;
    logic        [NB_DATA-1:0] result_r;
    logic        [NB_DATA-1:0] flags_r;
    logic                      tx_start;
    logic        [NB_DATA-1:0] tx_data;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state    <= WAIT_A;
            data_a   <= '0;
            data_b   <= '0;
            op_code  <= '0;
            result_r <= '0;
            flags_r  <= '0;
            tx_start <= 1'b0;
            tx_data  <= '0;
        end else begin
            tx_start <= 1'b0;
            case (state)
                WAIT_A: begin
                    if (bus.i_rx_done) begin
                        data_a <= bus.i_rx_data;
                        state  <= WAIT_B;
                    end
                end
                WAIT_B: begin
                    if (bus.i_rx_done) begin
                        data_b <= bus.i_rx_data;
                        state  <= WAIT_OP;
                    end
                end
                WAIT_OP: begin
                    if (bus.i_rx_done) begin
                        op_code <= bus.i_rx_data[NB_OP-1:0];
                        state   <= EXEC;
                    end
                end
                // Operands have been stable on the ALU for a full cycle here
                EXEC: begin
                    result_r <= bus.i_alu_result;
                    flags_r  <= {{(NB_DATA-2){1'b0}}, bus.i_alu_overflow, bus.i_alu_zero};
                    state    <= SEND_RES;
                end
                SEND_RES: begin
                    tx_start <= 1'b1;
                    tx_data  <= result_r;
                    state    <= WAIT_RES;
                end
                WAIT_RES: begin
                    if (bus.i_tx_done) state <= SEND_FLAGS;
                end
                SEND_FLAGS: begin
                    tx_start <= 1'b1;
                    tx_data  <= flags_r;
                    state    <= WAIT_FLAGS;
                end
                WAIT_FLAGS: begin
                    if (bus.i_tx_done) state <= WAIT_A;
                end
                default: state <= WAIT_A;
            endcase
        end
    end

    assign bus.o_data_a         = data_a;
    assign bus.o_data_b         = data_b;
    assign bus.o_operation_code = op_code;
    assign bus.o_tx_start       = tx_start;
    assign bus.o_tx_data        = tx_data;
    assign bus.o_busy           = (state == EXEC)     || (state == SEND_RES)   ||
                                  (state == WAIT_RES) || (state == SEND_FLAGS) ||
                                  (state == WAIT_FLAGS);
endmodule
